// File: rtl/approx_adder_pipe.sv
// approx_adder_pipe: two-stage valid/ready adder with selectable lower-part
// approximation and in-system error statistics against the exact sum.
module approx_adder_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH:0]   err_dist,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] err_sum,
    output logic [WIDTH:0]   max_err
);

    localparam int K  = APPROX_BITS;
    localparam int UW = WIDTH - K;
    localparam int EW = WIDTH + 1;
    localparam int SW = ((CNT_W > EW) ? CNT_W : EW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_cin;
    logic [1:0]       s1_mode;

    logic             advance;
    logic             accept;
    logic             xfer;

    logic [EW-1:0]    exact;
    logic [EW-1:0]    approx;
    logic [EW-1:0]    err;
    logic [K-1:0]     a_l;
    logic [K-1:0]     b_l;
    logic [K-1:0]     sum_l;
    logic [UW-1:0]    a_u;
    logic [UW-1:0]    b_u;
    logic [UW:0]      sum_u;
    logic             cu;
    logic [SW-1:0]    sum_ext;
    logic [CNT_W-1:0] err_sum_nxt;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | advance;
    assign accept   = in_valid & in_ready;
    assign xfer     = s1_valid & advance;

    // Approximate and exact sums of the S1 beat, plus their distance.
    always_comb begin
        a_l   = s1_a[K-1:0];
        b_l   = s1_b[K-1:0];
        a_u   = s1_a[WIDTH-1:K];
        b_u   = s1_b[WIDTH-1:K];
        exact = {1'b0, s1_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, s1_cin};
        sum_l = a_l;
        cu    = 1'b0;
        unique case (s1_mode)
            2'd0: begin
                sum_l = a_l;
                cu    = 1'b0;
            end
            2'd1: begin
                sum_l = a_l | b_l;
                cu    = a_l[K-1] & b_l[K-1];
            end
            2'd2: begin
                sum_l = a_l ^ b_l;
                cu    = 1'b0;
            end
            2'd3: begin
                sum_l = a_l;
                cu    = a_l[K-1] & b_l[K-1];
            end
        endcase
        sum_u  = {1'b0, a_u} + {1'b0, b_u} + {{UW{1'b0}}, cu};
        approx = (s1_mode == 2'd0) ? exact : {sum_u, sum_l};
        err    = (approx >= exact) ? (approx - exact) : (exact - approx);
        sum_ext = SW'(err_sum) + SW'(err);
        err_sum_nxt = (sum_ext > SW'(CNT_MAX)) ? CNT_MAX
                                               : sum_ext[CNT_W-1:0];
    end

    // S1: capture the operands on every input handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cin   <= 1'b0;
            s1_mode  <= 2'd0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_a     <= A;
                s1_b     <= B;
                s1_cin   <= cin;
                s1_mode  <= mode;
            end else if (xfer) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // S2: result register, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            err_dist  <= '0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                {cout, sum} <= approx;
                err_dist    <= err;
            end
        end
    end

    // Saturating error statistics, updated on each S1 to S2 move.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            err_sum    <= '0;
            max_err    <= '0;
        end else if (xfer) begin
            if (sample_cnt != CNT_MAX) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
            if ((err != '0) && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            err_sum <= err_sum_nxt;
            if (err > max_err) begin
                max_err <= err;
            end
        end
    end

endmodule
